// File: rtl/kulisch_cs_accumulator_pkg.sv
// Shared types and default sizes for the Kulisch carry-save accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kulisch_pkg;

    // Default geometry: 11-bit multiplier operands feeding an 80-bit exact accumulator.
    localparam int DEF_MW      = 11;
    localparam int DEF_ACC_W   = 80;
    localparam int DEF_SHIFT_W = 7;

    // Resolved product width and the largest alignment that keeps the product inside the accumulator.
    localparam int PW        = 2 * DEF_MW;
    localparam int MAX_SHIFT = DEF_ACC_W - PW;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    // Stage-1 register: resolved product plus its alignment and framing.
    typedef struct packed {
        logic [PW-1:0]          p;
        logic [DEF_SHIFT_W-1:0] shift;
        logic                   last;
        logic                   valid;
    } stage1_t;

endpackage

// File: rtl/kulisch_cs_accumulator_if.sv
// Product-in / result-out bundle between the multiplier array and the normaliser.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the product and result channels.
interface kulisch_cs_accumulator_if
    import kulisch_pkg::*;
#(
    parameter int MW      = DEF_MW,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SHIFT_W = DEF_SHIFT_W
);
    // Product channel (carry-save pair from the multiplier).
    logic                 in_valid;
    logic                 in_ready;
    logic [2*MW-1:0]      in_sum;
    logic [2*MW-1:0]      in_carry;
    logic [SHIFT_W-1:0]   in_shift;
    logic                 in_last;

    // Result channel (one word per dot-product).
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_data;
    logic                 out_ovf;
    logic                 out_rng_err;

    // Producer of products / consumer of results.
    modport master (
        output in_valid, in_sum, in_carry, in_shift, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_rng_err
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_sum, in_carry, in_shift, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_rng_err
    );

endinterface

// File: rtl/kulisch_cs_accumulator_align_add.sv
// Aligns a signed product into accumulator position and adds it, flagging overflow and bad shifts.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, result used only when stage 1 holds a product.
module kulisch_align_add
    import kulisch_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int P_W     = PW,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [P_W-1:0]     p,
    input  logic [SHIFT_W-1:0] shift,
    output logic [ACC_W-1:0]   acc_next,
    output logic               ovf,
    output logic               rng_err
);

    // Shifts beyond this would push product bits off the top of the register.
    localparam int MAX_SH = ACC_W - P_W;

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] term;
    logic [31:0]      shift_w;

    // Sign-extend, range-check, align and add; a dropped product contributes zero.
    always_comb begin
        p_ext    = {{(ACC_W-P_W){p[P_W-1]}}, p};
        shift_w  = {{(32-SHIFT_W){1'b0}}, shift};
        rng_err  = (shift_w > 32'(MAX_SH));
        term     = rng_err ? '0 : (p_ext << shift);
        acc_next = acc + term;
        // Same-sign operands producing a different-sign result means the signed range wrapped.
        ovf      = (acc[ACC_W-1] == term[ACC_W-1]) &&
                   (acc_next[ACC_W-1] != acc[ACC_W-1]);
    end

endmodule

// File: rtl/kulisch_cs_accumulator.sv
// Resolves carry-save products, aligns them and accumulates exactly; emits one result per dot-product.
// Latency: result valid 2 edges after the accept edge of the last product (accept, then stage 2).
// Backpressure: in_ready drops from the last accept until the result is taken by out_ready.
module kulisch_cs_accumulator
    import kulisch_pkg::*;
#(
    parameter int MW      = DEF_MW,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    kulisch_cs_accumulator_if.slave  bus
);

    localparam int PRW = 2 * MW;

    acc_state_t        state;
    acc_state_t        state_nxt;
    stage1_t           s1;

    logic [PRW-1:0]    p_cs;
    logic              accept;
    logic              out_fire;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic              ovf_now;
    logic              rng_now;
    logic              ovf_st;
    logic              rng_st;

    logic              out_valid_q;
    logic [ACC_W-1:0]  out_data_q;
    logic              out_ovf_q;
    logic              out_rng_q;

    // Carry-propagate resolve of the multiplier's redundant pair; wraps mod 2^PW.
    assign p_cs = bus.in_sum + bus.in_carry;

    // Ready is a state decode; held low while reset is asserted.
    assign bus.in_ready = rst_n && (state == ACCUM);
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid_q && bus.out_ready;

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_ovf     = out_ovf_q;
    assign bus.out_rng_err = out_rng_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: close the frame on the last accept, drain one cycle, then hold the result.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (accept && bus.in_last) state_nxt = FLUSH;
            FLUSH: state_nxt = HOLD;
            HOLD:  if (out_fire) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Stage 1: capture the resolved product with its alignment and framing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else begin
            s1.valid <= accept;
            if (accept) begin
                s1.p     <= p_cs;
                s1.shift <= bus.in_shift;
                s1.last  <= bus.in_last;
            end
        end
    end

    kulisch_align_add #(
        .ACC_W   (ACC_W),
        .P_W     (PRW),
        .SHIFT_W (SHIFT_W)
    ) u_align_add (
        .acc      (acc),
        .p        (s1.p),
        .shift    (s1.shift),
        .acc_next (acc_nxt),
        .ovf      (ovf_now),
        .rng_err  (rng_now)
    );

    // Stage 2: fold the product into the accumulator; the last product restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            ovf_st <= 1'b0;
            rng_st <= 1'b0;
        end else if (s1.valid) begin
            if (s1.last) begin
                acc    <= '0;
                ovf_st <= 1'b0;
                rng_st <= 1'b0;
            end else begin
                acc    <= acc_nxt;
                ovf_st <= ovf_st | ovf_now;
                rng_st <= rng_st | rng_now;
            end
        end
    end

    // Result register: loaded by the last product, held until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_rng_q   <= 1'b0;
        end else if (s1.valid && s1.last) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_nxt;
            out_ovf_q   <= ovf_st | ovf_now;
            out_rng_q   <= rng_st | rng_now;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: doc/kulisch_cs_accumulator.md
Name: kulisch_cs_accumulator

Overview:
- Consumer end of the Booth/Wallace multiplier interface: takes the multiplier's carry-save pair (sum, carry) for each product and resolves it with a carry-propagate add to a signed 2*MW-bit product.
- Aligns the product by an exponent-derived left shift and accumulates it exactly into a wide Kulisch register.
- Emits the final accumulator value once per dot-product, marked by a last flag.
- Sits between the TensorCore multiplier array and the normalisation/rounding stage.

Parameters:
- MW, 11: multiplier operand width; product width PW = 2*MW.
- ACC_W, 80: Kulisch accumulator width; must be > PW.
- SHIFT_W, 7: width of the alignment shift field.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product pair valid
- in_ready  output  1  block can accept a product
- in_sum  input  PW  carry-save sum row from the multiplier
- in_carry  input  PW  carry-save carry row from the multiplier
- in_shift  input  SHIFT_W  left alignment shift of the product, in bits
- in_last  input  1  final product of the current dot-product
- out_valid  output  1  accumulated result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  ACC_W  signed accumulated result
- out_ovf  output  1  sticky signed overflow seen during this dot-product
- out_rng_err  output  1  sticky: a product had an out-of-range shift and was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: in_ready=0 during reset, out_valid=0, out_data=0, out_ovf=0, out_rng_err=0. The accumulator and pipeline valid bit are 0. The state is ACCUM.
- Input handshake: a product is accepted on a rising edge with in_valid & in_ready. in_ready = (state==ACCUM). It is a registered-state decode, not combinationally dependent on in_valid.
- Stage 1 (accept edge E0):
  - Register p = (in_sum + in_carry) mod 2^PW, interpreted as a signed PW-bit value.
  - Also register shift and last, and set the stage valid bit.
- Stage 2 (edge E1):
  - term = sign_extend(p, ACC_W) << shift.
  - acc_next = acc + term, computed mod 2^ACC_W.
- Range check:
  - Legal shift range is 0..ACC_W-PW.
  - If shift > ACC_W-PW, term is treated as 0 and the rng_err sticky bit is set.
- Overflow detection:
  - Overflow occurs when acc and term have the same sign and acc_next has a different sign. This sets the ovf sticky bit.
  - The wrapped sum is still stored.
- Last product:
  - If the stage-2 product has last=1, then at E1: out_data <= acc_next, out_valid <= 1, out_ovf/out_rng_err <= the sticky values including this cycle's event, and acc and the stickies are cleared to 0.
  - Latency is 2 cycles from the accept edge to out_valid.
- State machine:
  - ACCUM: accepting products. Accepting a product with in_last=1 goes to FLUSH.
  - FLUSH: in_ready=0; waits for the last product to leave stage 2, which takes exactly one cycle, then goes to HOLD.
  - HOLD: out_valid=1. out_data and flags are held stable until out_valid & out_ready. At that handshake: out_valid <= 0 and go to ACCUM.
- Throughput: one product per cycle in ACCUM. Back-to-back products chain through stage 2 with no bubble.
- out_ready behaviour: if out_ready is already 1 when HOLD is entered, the handshake completes on the first HOLD cycle, and in_ready returns the next cycle.
- Mid-stream reset: asserting rst_n low discards the in-flight pipeline product, the accumulator and a pending result, with no output.
- Stable inputs: in_sum and in_carry are ignored while in_ready=0. The multiplier must hold them stable until acceptance.
- Products with p = 0 still advance state; in_last on a zero product still produces output.

Decomposition:
- Package kulisch_pkg:
  - localparams PW and MAX_SHIFT = ACC_W-PW.
  - enum acc_state_t {ACCUM, FLUSH, HOLD}.
  - A packed struct for the stage-1 register: p, shift, last, valid.
- One sub-module, kulisch_align_add (combinational). It takes acc, p and shift and returns acc_next, ovf and rng_err. The main module holds the FSM, handshakes and registers.

Test Plan:
- Single product, PW=22: in_sum=22'h3FFFF0, in_carry=22'h000001, shift=0, last=1 -> out_data = -15 (80'hFFFF_FFFF_FFFF_FFFF_FFF1) two cycles after accept; out_ovf=0, out_rng_err=0.
- Three back-to-back products, continuous valid: p=+3 shift=0, p=+3 shift=2, p=-1 shift=4, last on the third -> out_data = 3+12-16 = -1. in_ready is low from the cycle after the last accept until the output handshake.
- Overflow: MW=11, ACC_W=24. p=22'h1FFFFF shift=2, then the same product again with last -> out_ovf=1, and out_data equals the wrapped 24-bit sum.
- Out-of-range: shift=ACC_W-PW+1 on p=5, followed by p=2 shift=0 last -> out_data=2, out_rng_err=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data is stable, in_ready=0, and no product is accepted. out_ready=1 -> handshake, and in_ready=1 on the next cycle. The next dot-product starts from acc=0 with the stickies cleared.
- Reset mid-operation: assert rst_n low while FLUSH is pending -> out_valid stays 0. After release, a fresh p=7 last -> out_data=7.
